shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle controller that sequences one shared 64-bit left barrel shifter (`barrel_shifter_left`, instantiated inside this block) to perform SLL, SRL and SRA for the ALU.
- Right shifts use bit-reversal around the left shifter.
- SRA sign fill uses a second pass through the same shifter, so no second shifter is needed.
- Sits between ALU issue (valid/ready in) and ALU writeback (valid/ready out).

Parameters:
- XLEN, 64, datapath width; only 64 is supported, must match the shifter.
- SHAMT_W, 6, shift-amount bits used; fixed as log2(XLEN).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of any in-flight operation.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_op  input  2  00=SLL, 01=SRL, 10=SRA, 11=reserved (executed as SLL).
- in_data  input  64  operand.
- in_shamt  input  64  shift amount; only bits [5:0] are used, bits [63:6] are ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  64  result.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - out_valid=0, out_data=0, in_ready=1.
  - All internal registers are 0.
- in_ready = (state==IDLE). There is no overlap: one operation is in flight at a time.
- Acceptance is in_valid & in_ready at a rising edge. It latches:
  - op
  - amt = in_shamt[5:0]
  - sign = in_data[63]
  - opnd = in_data for SLL/reserved, bitrev(in_data) for SRL/SRA.
- FSM states: IDLE, PASS1, PASS2, DONE.
  - IDLE -> PASS1 on acceptance.
  - PASS1:
    - Shifter inputs are data=opnd, shift=amt.
    - Register res = shout for SLL, bitrev(shout) for SRL/SRA.
    - Next state is PASS2 if op==SRA & sign==1 & amt!=0, else DONE.
  - PASS2:
    - Shifter inputs are data=all-ones, shift=amt.
    - res <= res | ~bitrev(shout), which sets the top amt bits.
    - Next state is DONE.
  - DONE:
    - out_valid=1, out_data=res.
    - On out_ready, go to IDLE at that edge.
    - out_data holds stable while out_valid=1 & out_ready=0.
- Latency from the acceptance edge to out_valid high:
  - 2 cycles for SLL, SRL, and SRA with non-negative operand or amt=0.
  - 3 cycles for SRA with negative operand and amt!=0.
- Throughput: minimum 3 cycles per op (accept, PASS1, DONE with immediate out_ready).
- out_valid is registered: it depends only on state, not combinationally on inputs.
- amt=0 returns in_data unchanged for all ops.
- Shift amounts of 64 and above wrap modulo 64.
- flush=1 at an edge:
  - Next state is IDLE from any state; the in-flight result is discarded and out_valid deasserts the next cycle.
  - flush has priority over acceptance and over out_ready; a request presented in IDLE with flush=1 is not accepted.
- Reset mid-operation aborts immediately: outputs return to their reset values asynchronously.
- Input ports are not sampled outside IDLE; changes to them during PASS1/PASS2/DONE have no effect.

Test Plan:
- SLL: data=0x1, shamt=63 -> out_data=0x8000_0000_0000_0000, out_valid 2 cycles after accept.
- SRL: data=0xF0, shamt=4 -> 0x0F. SRL: data=0x8000_0000_0000_0000, shamt=63 -> 0x1.
- SRA, both passes:
  - data=0x8000_0000_0000_0000, shamt=4 -> 0xF800_0000_0000_0000, out_valid 3 cycles after accept.
  - data=0x7FFF_FFFF_FFFF_FFFF, shamt=4 -> 0x07FF_FFFF_FFFF_FFFF in 2 cycles.
- Masking:
  - SLL data=0x5A, shamt=64 -> 0x5A.
  - SRA data=0xFFFF_FFFF_FFFF_FF00, shamt=0x48 (amt 8) -> 0xFFFF_FFFF_FFFF_FFFF.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 next cycle; back-to-back requests are accepted every 3 cycles.
- Abort:
  - Assert flush during PASS1 of an SRA -> out_valid never rises, in_ready=1 next cycle.
  - Pulse rst_n low during DONE -> out_valid=0 and out_data=0 immediately.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA sequencer around one shared 64-bit left barrel shifter.
// Right shifts bit-reverse around the shifter; SRA sign fill reuses it in a second pass.

module barrel_shifter_left #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned SHAMT_W = 6
) (
  input  logic [XLEN-1:0]    i_data,
  input  logic [SHAMT_W-1:0] i_shift,
  output logic [XLEN-1:0]    o_data
);

  logic [XLEN-1:0] w_stage [SHAMT_W+1];

  assign w_stage[0] = i_data;

  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    assign w_stage[s+1] = i_shift[s] ? (w_stage[s] << (1 << s)) : w_stage[s];
  end

  assign o_data = w_stage[SHAMT_W];

endmodule

module shift_sequencer #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned SHAMT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_data,
  input  logic [XLEN-1:0] in_shamt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_e;
  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_RSV = 2'b11} op_e;

  state_e              r_state;
  state_e              w_state_nxt;
  op_e                 r_op;
  logic [SHAMT_W-1:0]  r_amt;
  logic                r_sign;
  logic [XLEN-1:0]     r_opnd;
  logic [XLEN-1:0]     r_res;

  logic                w_accept;
  logic                w_in_right;
  logic                w_right;
  logic [XLEN-1:0]     w_in_rev;
  logic [XLEN-1:0]     w_sh_data;
  logic [XLEN-1:0]     w_shout;
  logic [XLEN-1:0]     w_shout_rev;

  assign w_in_rev    = {<<{in_data}};
  assign w_shout_rev = {<<{w_shout}};
  assign w_in_right  = (in_op == OP_SRL) || (in_op == OP_SRA);
  assign w_right     = (r_op == OP_SRL) || (r_op == OP_SRA);

  // Second pass shifts all-ones so its reversed complement is a mask of the top amt bits.
  assign w_sh_data = (r_state == PASS2) ? '1 : r_opnd;

  barrel_shifter_left #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .i_data  (w_sh_data),
    .i_shift (r_amt),
    .o_data  (w_shout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = PASS1;
        end
      end
      PASS1: begin
        if ((r_op == OP_SRA) && r_sign && (r_amt != '0)) w_state_nxt = PASS2;
        else                                               w_state_nxt = DONE;
      end
      PASS2: w_state_nxt = DONE;
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_accept    = 1'b0;
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= OP_SLL;
      r_amt   <= '0;
      r_sign  <= 1'b0;
      r_opnd  <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op   <= op_e'(in_op);
        r_amt  <= in_shamt[SHAMT_W-1:0];
        r_sign <= in_data[XLEN-1];
        r_opnd <= w_in_right ? w_in_rev : in_data;
      end
      if (r_state == PASS1) r_res <= w_right ? w_shout_rev : w_shout;
      if (r_state == PASS2) r_res <= r_res | ~w_shout_rev;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = out_valid ? r_res : '0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: results, latency, masking, backpressure, flush and reset.

module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [63:0] in_data;
  logic [63:0] in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  shift_sequencer #(
    .XLEN    (64),
    .SHAMT_W (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Presents one request, checks latency and result; optionally drains it.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] d,
                        input logic [63:0] s, input logic [63:0] exp, input int lat,
                        input bit drain);
    int edges;
    bit got;
    @(negedge clk);
    in_op = op; in_data = d; in_shamt = s; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    edges = 1;
    #1;
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_data  = {$urandom, $urandom};
    in_shamt = {$urandom, $urandom};
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    chk({tag, "_valid"}, 64'(got), 64'd1);
    chk({tag, "_lat"}, 64'(edges), 64'(lat));
    chk({tag, "_data"}, out_data, exp);
    if (drain) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
      chk({tag, "_idle_vld"}, 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    int acc;
    int nres;
    bit seen;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; in_data = '0; in_shamt = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("sll63",  2'b00, 64'h1, 64'd63, 64'h8000_0000_0000_0000, 2, 1'b1);
    run_op("srl4",   2'b01, 64'hF0, 64'd4, 64'h0F, 2, 1'b1);
    run_op("srl63",  2'b01, 64'h8000_0000_0000_0000, 64'd63, 64'h1, 2, 1'b1);
    run_op("sra_neg", 2'b10, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 3, 1'b1);
    run_op("sra_pos", 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'd4, 64'h07FF_FFFF_FFFF_FFFF, 2, 1'b1);
    run_op("sll_w64", 2'b00, 64'h5A, 64'd64, 64'h5A, 2, 1'b1);
    run_op("sra_w72", 2'b10, 64'hFFFF_FFFF_FFFF_FF00, 64'h48, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b1);
    run_op("sra_a0", 2'b10, 64'h8000_0000_0000_0001, 64'd0, 64'h8000_0000_0000_0001, 2, 1'b1);
    run_op("srl_a0", 2'b01, 64'hDEAD_BEEF_0123_4567, 64'd0, 64'hDEAD_BEEF_0123_4567, 2, 1'b1);
    run_op("rsv",    2'b11, 64'h1, 64'd4, 64'h10, 2, 1'b1);
    run_op("sra_hi", 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFC1,
           64'hC000_0000_0000_0000, 3, 1'b1);
    run_op("srl_32", 2'b01, 64'h1234_5678_9ABC_DEF0, 64'd32, 64'h0000_0000_1234_5678, 2, 1'b1);

    // Backpressure: result held while out_ready is low.
    run_op("bp", 2'b01, 64'hF000_0000_0000_0000, 64'd8, 64'h00F0_0000_0000_0000, 2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_data", out_data, 64'h00F0_0000_0000_0000);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_rdy", 64'(in_ready), 64'd1);

    // Back-to-back: in_valid and out_ready held high; one accept every 3 cycles.
    in_op = 2'b00; in_data = 64'h3; in_shamt = 64'd2; in_valid = 1'b1; out_ready = 1'b1;
    acc = 0; nres = 0;
    for (int i = 0; i < 9; i++) begin
      if (in_ready) acc++;
      if (out_valid) begin
        nres++;
        chk("b2b_data", out_data, 64'hC);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_accepts", 64'(acc), 64'd3);
    chk("b2b_results", 64'(nres), 64'd3);

    // Flush during PASS1 of a two-pass SRA.
    @(negedge clk);
    in_op = 2'b10; in_data = 64'h8000_0000_0000_0000; in_shamt = 64'd4; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_p1_rdy", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen = seen | out_valid;
      @(negedge clk);
    end
    chk("flush_p1_novalid", 64'(seen), 64'd0);

    // Flush beats acceptance in IDLE.
    in_op = 2'b00; in_data = 64'h1; in_shamt = 64'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_rdy", 64'(in_ready), 64'd1);

    // Flush beats out_ready in DONE.
    run_op("fl_done", 2'b00, 64'h1, 64'd1, 64'h2, 2, 1'b0);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("flush_done_vld", 64'(out_valid), 64'd0);
    chk("flush_done_rdy", 64'(in_ready), 64'd1);

    // Asynchronous reset during DONE.
    run_op("rst_done", 2'b10, 64'hFFFF_0000_0000_0000, 64'd16, 64'hFFFF_FFFF_0000_0000, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", out_data, 64'd0);
    chk("arst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("post_rst", 2'b01, 64'h8000_0000_0000_0000, 64'd1, 64'h4000_0000_0000_0000, 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
